// File: rtl/rot_task_sched_pkg.sv
// Shared definitions for the rotation task scheduler: FSM encoding and the
// mode value that means "cancel".
package rot_task_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int MODE_CANCEL = 0;

endpackage

// File: rtl/rot_task_slot.sv
// Single pending-task register. Load wins over clear/take. o_drop flags that a
// valid entry is being discarded (overwritten or cancelled), not handed on.
module rot_task_slot
  import rot_task_sched_pkg::*;
#(
  parameter int MODE_W = 3,
  parameter int DEG_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic              i_take,
  input  logic [MODE_W-1:0] i_mode,
  input  logic [DEG_W-1:0]  i_deg,
  output logic              o_vld,
  output logic [MODE_W-1:0] o_mode,
  output logic [DEG_W-1:0]  o_deg,
  output logic              o_drop
);

  logic              vld_q, vld_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [DEG_W-1:0]  deg_q, deg_d;

  always_comb begin
    vld_d  = vld_q;
    mode_d = mode_q;
    deg_d  = deg_q;
    if (i_load) begin
      vld_d  = 1'b1;
      mode_d = i_mode;
      deg_d  = i_deg;
    end else if (i_clr || i_take) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q  <= 1'b0;
      mode_q <= '0;
      deg_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      deg_q  <= deg_d;
    end
  end

  // take (moving the entry into the request fields) is a hand-off, not a drop
  assign o_drop = vld_q & (i_load | i_clr);
  assign o_vld  = vld_q;
  assign o_mode = mode_q;
  assign o_deg  = deg_q;

endmodule

// File: rtl/rot_task_sched.sv
// Task scheduler between the mode/degree front-end and the shared rotation
// engine: req/gnt issue, one coalescing pending slot, completion timeout.
module rot_task_sched
  import rot_task_sched_pkg::*;
#(
  parameter int MODE_W  = 3,
  parameter int DEG_W   = 6,
  parameter int TIMEOUT = 1024,
  parameter int DROP_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_newtask,
  input  logic [MODE_W-1:0] i_mode,
  input  logic [DEG_W-1:0]  i_deg,
  output logic              o_req,
  output logic [MODE_W-1:0] o_req_mode,
  output logic [DEG_W-1:0]  o_req_deg,
  input  logic              i_gnt,
  input  logic              i_done,
  output logic              o_busy,
  output logic              o_pend,
  output logic              o_timeout,
  output logic [DROP_W-1:0] o_drop_cnt
);

  localparam int          TMR_W = $clog2(TIMEOUT);
  localparam [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  state_e            state_q, state_d;
  logic [MODE_W-1:0] req_mode_q, req_mode_d;
  logic [DEG_W-1:0]  req_deg_q, req_deg_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              timeout_q, timeout_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic              new_task, cancel, run_exit;
  logic              req_drop;
  logic              slot_load, slot_clr, slot_take, slot_drop, pend_vld;
  logic [MODE_W-1:0] pend_mode;
  logic [DEG_W-1:0]  pend_deg;

  rot_task_slot #(
    .MODE_W (MODE_W),
    .DEG_W  (DEG_W)
  ) u_slot (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (slot_load),
    .i_clr   (slot_clr),
    .i_take  (slot_take),
    .i_mode  (i_mode),
    .i_deg   (i_deg),
    .o_vld   (pend_vld),
    .o_mode  (pend_mode),
    .o_deg   (pend_deg),
    .o_drop  (slot_drop)
  );

  assign new_task = i_newtask && (i_mode != MODE_W'(MODE_CANCEL));
  assign cancel   = i_newtask && (i_mode == MODE_W'(MODE_CANCEL));
  assign run_exit = i_done || (timer_q == TMR_MAX);

  always_comb begin
    state_d    = state_q;
    req_mode_d = req_mode_q;
    req_deg_d  = req_deg_q;
    timer_d    = timer_q;
    timeout_d  = 1'b0;
    req_drop   = 1'b0;
    slot_load  = 1'b0;
    slot_clr   = 1'b0;
    slot_take  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (new_task) begin
          req_mode_d = i_mode;
          req_deg_d  = i_deg;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        // a grant in the same cycle always wins over a new task or cancel
        if (i_gnt) begin
          state_d   = ST_RUN;
          timer_d   = '0;
          slot_load = new_task;
          slot_clr  = cancel;
        end else if (new_task) begin
          req_mode_d = i_mode;
          req_deg_d  = i_deg;
          req_drop   = 1'b1;
        end else if (cancel) begin
          state_d  = ST_IDLE;
          req_drop = 1'b1;
        end
      end
      ST_RUN: begin
        timer_d = timer_q + TMR_W'(1);
        if (run_exit) begin
          timeout_d = !i_done;
          timer_d   = '0;
          state_d   = ST_IDLE;
          if (new_task) begin
            req_mode_d = i_mode;
            req_deg_d  = i_deg;
            slot_clr   = 1'b1;
            state_d    = ST_REQ;
          end else if (cancel) begin
            slot_clr = 1'b1;
          end else if (pend_vld) begin
            req_mode_d = pend_mode;
            req_deg_d  = pend_deg;
            slot_take  = 1'b1;
            state_d    = ST_REQ;
          end
        end else begin
          slot_load = new_task;
          slot_clr  = cancel;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_d  = (state_d == ST_REQ);
    busy_d = (state_d != ST_IDLE);
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (req_drop || slot_drop) drop_cnt_d = sat_inc(drop_cnt_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      req_mode_q <= '0;
      req_deg_q  <= '0;
      timer_q    <= '0;
      timeout_q  <= 1'b0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      req_mode_q <= req_mode_d;
      req_deg_q  <= req_deg_d;
      timer_q    <= timer_d;
      timeout_q  <= timeout_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_req      = req_q;
  assign o_req_mode = req_mode_q;
  assign o_req_deg  = req_deg_q;
  assign o_busy     = busy_q;
  assign o_pend     = pend_vld;
  assign o_timeout  = timeout_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule
